// File: rtl/elderly_pkg.sv
// elderly_pkg: shared state enums, limits, defaults and saturating helper
package elderly_pkg;
    typedef enum logic {M_IDLE, M_RUN} main_state_t;
    typedef enum logic [1:0] {E_IDLE, E_WAIT, E_EVAL} eval_state_t;
    localparam logic [7:0] COUNT_MAX = 8'hFF;
    localparam logic [3:0] STREAK_MAX = 4'hF;
    localparam int DEF_TICKS_PER_SEC = 50_000_000;
    localparam int DEF_WINDOW_SEC = 15;
    localparam int DEF_BPM_LATENCY = 1;
    localparam int DEF_ALARM_WINDOWS = 3;
    function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic inc);
        return (v == COUNT_MAX) ? v : v + {7'd0, inc};
    endfunction
endpackage

// File: rtl/bpm_window_scheduler_if.sv
// bpm_window_scheduler_if: sensor, monitor and alert signals of the window scheduler
interface bpm_window_scheduler_if;
    logic       enable;
    logic       pulse_in;
    logic       bpm_state_in;
    logic       alarm_ack;
    logic [7:0] pulse_count;
    logic       count_valid;
    logic       window_active;
    logic [3:0] abnormal_streak;
    logic       alarm;
    modport master (
        input  enable, pulse_in, bpm_state_in, alarm_ack,
        output pulse_count, count_valid, window_active, abnormal_streak, alarm
    );
    modport slave (
        output enable, pulse_in, bpm_state_in, alarm_ack,
        input  pulse_count, count_valid, window_active, abnormal_streak, alarm
    );
endinterface

// File: rtl/pulse_edge_sync.sv
// pulse_edge_sync: 2-FF synchronizer with registered rising-edge strobe
module pulse_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);
    logic [2:0] sr;
    // sr[1:0] synchronize, sr[2] holds the previous synchronized level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
            rise <= 1'b0;
        end else begin
            sr <= {sr[1:0], async_in};
            rise <= sr[1] & ~sr[2];
        end
    end
endmodule

// File: rtl/bpm_window_scheduler.sv
// bpm_window_scheduler: timed pulse-count windows with verdict streak and sticky alarm
module bpm_window_scheduler
    import elderly_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int WINDOW_SEC    = DEF_WINDOW_SEC,
    parameter int BPM_LATENCY   = DEF_BPM_LATENCY,
    parameter int ALARM_WINDOWS = DEF_ALARM_WINDOWS
) (
    input logic clk,
    input logic reset,
    bpm_window_scheduler_if.master bus
);
    localparam int WINDOW_CYCLES = TICKS_PER_SEC * WINDOW_SEC;
    localparam int TW = $clog2(WINDOW_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(WINDOW_CYCLES - 1);
    localparam logic [3:0] LAT_LAST = 4'(BPM_LATENCY - 1);
    localparam logic [3:0] ALARM_TH = 4'(ALARM_WINDOWS);
    main_state_t m_state;
    eval_state_t e_state;
    logic [TW-1:0] timer;
    logic [7:0] edge_cnt, cnt_next, pulse_count;
    logic [3:0] wait_cnt, streak, streak_next;
    logic pulse_edge, terminal, count_valid, window_active, alarm, alarm_set;
    pulse_edge_sync u_sync (
        .clk(clk),
        .reset(reset),
        .async_in(bus.pulse_in),
        .rise(pulse_edge)
    );
    // window end, saturating count and streak update for the evaluation cycle
    always_comb begin
        terminal = timer == T_LAST;
        cnt_next = sat_add8(edge_cnt, pulse_edge);
        streak_next = bus.bpm_state_in ? ((streak == STREAK_MAX) ? STREAK_MAX : streak + 4'd1) : 4'd0;
        alarm_set = bus.enable && e_state == E_EVAL && streak_next >= ALARM_TH;
    end
    // main FSM: back-to-back windows, abort discards the open window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= M_IDLE;
            timer <= '0;
            edge_cnt <= '0;
            pulse_count <= '0;
            count_valid <= 1'b0;
            window_active <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (m_state == M_IDLE) begin
                timer <= '0;
                edge_cnt <= '0;
                m_state <= bus.enable ? M_RUN : M_IDLE;
                window_active <= bus.enable;
            end else if (!bus.enable) begin
                m_state <= M_IDLE;
                window_active <= 1'b0;
            end else if (terminal) begin
                pulse_count <= cnt_next;
                edge_cnt <= '0;
                timer <= '0;
                count_valid <= 1'b1;
            end else begin
                edge_cnt <= cnt_next;
                timer <= timer + TW'(1);
            end
        end
    end
    // eval FSM: wait out monitor latency, fold verdict into streak and alarm
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_state <= E_IDLE;
            wait_cnt <= '0;
            streak <= '0;
            alarm <= 1'b0;
        end else begin
            if (!bus.enable) begin
                e_state <= E_IDLE;
                streak <= '0;
            end else if (e_state == E_IDLE) begin
                e_state <= count_valid ? E_WAIT : E_IDLE;
                wait_cnt <= '0;
            end else if (e_state == E_WAIT) begin
                e_state <= (wait_cnt == LAT_LAST) ? E_EVAL : E_WAIT;
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                e_state <= E_IDLE;
                streak <= streak_next;
            end
            alarm <= alarm_set ? 1'b1 : (bus.alarm_ack ? 1'b0 : alarm);
        end
    end
    assign bus.pulse_count = pulse_count;
    assign bus.count_valid = count_valid;
    assign bus.window_active = window_active;
    assign bus.abnormal_streak = streak;
    assign bus.alarm = alarm;
endmodule

// File: tb/tb_bpm_window_scheduler.sv
// tb_bpm_window_scheduler: directed window vectors plus reset, abort, boundary and saturation sequences
module tb_bpm_window_scheduler;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;
    bpm_window_scheduler_if bus_a ();
    bpm_window_scheduler_if bus_b ();
    bpm_window_scheduler #(
        .TICKS_PER_SEC(10), .WINDOW_SEC(2), .BPM_LATENCY(1), .ALARM_WINDOWS(3)
    ) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a)
    );
    bpm_window_scheduler #(
        .TICKS_PER_SEC(400), .WINDOW_SEC(2), .BPM_LATENCY(1), .ALARM_WINDOWS(3)
    ) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b)
    );
    typedef struct {
        int   n;
        logic bst;
        logic ack;
        int   exp_count;
        int   exp_streak;
        int   exp_alarm;
    } vec_t;
    vec_t vecs[10];
    int cyc, total, passed;
    logic seen;
    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask
    task automatic goto(input int t);
        while (cyc < t) tick();
    endtask
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask
    task automatic pulse_a();
        bus_a.pulse_in = 1'b1;
        tick();
        bus_a.pulse_in = 1'b0;
        tick();
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_count"}, int'(bus_a.pulse_count), 0);
        chk({tag, "_cv"}, int'(bus_a.count_valid), 0);
        chk({tag, "_wa"}, int'(bus_a.window_active), 0);
        chk({tag, "_streak"}, int'(bus_a.abnormal_streak), 0);
        chk({tag, "_alarm"}, int'(bus_a.alarm), 0);
    endtask
    initial begin
        vecs = '{
            '{7, 1'b0, 1'b0, 7, 0, 0},
            '{0, 1'b1, 1'b0, 0, 1, 0},
            '{3, 1'b1, 1'b0, 3, 2, 0},
            '{5, 1'b1, 1'b0, 5, 3, 1},
            '{1, 1'b0, 1'b0, 1, 0, 1},
            '{2, 1'b0, 1'b1, 2, 0, 0},
            '{4, 1'b1, 1'b0, 4, 1, 0},
            '{6, 1'b1, 1'b0, 6, 2, 0},
            '{7, 1'b1, 1'b1, 7, 3, 1},
            '{0, 1'b1, 1'b0, 0, 4, 1}
        };
        total = 0;
        passed = 0;
        cyc = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.enable = 1'b0;
        bus_a.pulse_in = 1'b0;
        bus_a.bpm_state_in = 1'b0;
        bus_a.alarm_ack = 1'b0;
        bus_b.enable = 1'b0;
        bus_b.pulse_in = 1'b0;
        bus_b.bpm_state_in = 1'b0;
        bus_b.alarm_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_a = 1'b0;
        tick();
        bus_a.enable = 1'b1;
        cyc = 0;
        chk("wa_before_run", int'(bus_a.window_active), 0);
        goto(1);
        chk("wa_rise", int'(bus_a.window_active), 1);
        for (int i = 0; i < 10; i++) begin
            goto(20 * i + 4);
            for (int k = 0; k < vecs[i].n; k++) pulse_a();
            chk($sformatf("v%0d_wa", i), int'(bus_a.window_active), 1);
            goto(20 * i + 20);
            chk($sformatf("v%0d_cv_early", i), int'(bus_a.count_valid), 0);
            goto(20 * i + 21);
            chk($sformatf("v%0d_cv", i), int'(bus_a.count_valid), 1);
            chk($sformatf("v%0d_count", i), int'(bus_a.pulse_count), vecs[i].exp_count);
            bus_a.bpm_state_in = vecs[i].bst;
            goto(20 * i + 22);
            chk($sformatf("v%0d_cv_strobe", i), int'(bus_a.count_valid), 0);
            goto(20 * i + 23);
            bus_a.alarm_ack = vecs[i].ack;
            goto(20 * i + 24);
            chk($sformatf("v%0d_streak", i), int'(bus_a.abnormal_streak), vecs[i].exp_streak);
            chk($sformatf("v%0d_alarm", i), int'(bus_a.alarm), vecs[i].exp_alarm);
            bus_a.alarm_ack = 1'b0;
        end
        goto(218);
        pulse_a();
        goto(221);
        chk("late_edge_not_in_closing", int'(bus_a.pulse_count), 0);
        goto(224);
        chk("streak_5", int'(bus_a.abnormal_streak), 5);
        goto(237);
        pulse_a();
        goto(241);
        chk("terminal_edge_counted", int'(bus_a.pulse_count), 2);
        goto(244);
        chk("streak_6", int'(bus_a.abnormal_streak), 6);
        goto(245);
        pulse_a();
        goto(261);
        chk("w12_count", int'(bus_a.pulse_count), 1);
        goto(264);
        chk("streak_7", int'(bus_a.abnormal_streak), 7);
        chk("alarm_held", int'(bus_a.alarm), 1);
        goto(265);
        pulse_a();
        goto(271);
        bus_a.enable = 1'b0;
        goto(272);
        chk("abort_wa", int'(bus_a.window_active), 0);
        chk("abort_streak", int'(bus_a.abnormal_streak), 0);
        chk("abort_alarm", int'(bus_a.alarm), 1);
        seen = 1'b0;
        while (cyc < 290) begin
            tick();
            if (bus_a.count_valid) seen = 1'b1;
        end
        chk("abort_no_cv", int'(seen), 0);
        chk("abort_count_hold", int'(bus_a.pulse_count), 1);
        bus_a.enable = 1'b1;
        goto(295);
        chk("pre_reset_alarm", int'(bus_a.alarm), 1);
        chk("pre_reset_wa", int'(bus_a.window_active), 1);
        #2;
        rst_a = 1'b1;
        #1;
        chk_zero("async_reset");
        bus_a.enable = 1'b0;
        tick();
        rst_a = 1'b0;
        tick();
        bus_a.enable = 1'b1;
        cyc = 0;
        seen = 1'b0;
        while (cyc < 20) begin
            tick();
            if (bus_a.count_valid) seen = 1'b1;
        end
        chk("rerun_no_early_cv", int'(seen), 0);
        tick();
        chk("rerun_cv_at_21", int'(bus_a.count_valid), 1);
        chk("rerun_count", int'(bus_a.pulse_count), 0);
        rst_b = 1'b0;
        bus_b.enable = 1'b1;
        tick();
        repeat (300) begin
            bus_b.pulse_in = 1'b1;
            tick();
            bus_b.pulse_in = 1'b0;
            tick();
        end
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            tick();
            if (bus_b.count_valid) seen = 1'b1;
        end
        chk("sat_cv_seen", int'(seen), 1);
        chk("sat_count", int'(bus_b.pulse_count), 255);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bpm_window_scheduler.md
# bpm_window_scheduler

Measurement-window controller in front of BPM_Monitor. It synchronizes the raw heartbeat pulse input and counts rising edges over a fixed, back-to-back timed window. At each window end it presents the count on `pulse_count`, waits for the monitor's registered verdict, and escalates consecutive abnormal verdicts into a sticky alarm for the alert path.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clk cycles per second (50 MHz).
- `WINDOW_SEC`, default 15: window length in seconds; `WINDOW_CYCLES` = `TICKS_PER_SEC*WINDOW_SEC`.
- `BPM_LATENCY`, default 1: cycles from `count_valid` until `bpm_state_in` is valid; legal range 1..15.
- `ALARM_WINDOWS`, default 3: consecutive abnormal windows that raise `alarm`; legal range 1..15.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `enable`  in  1  level; 1 = run windows continuously, 0 = abort and idle.
- `pulse_in`  in  1  raw sensor pulse, asynchronous to `clk`.
- `bpm_state_in`  in  1  BPM_Monitor `bpm_state`; 1 = abnormal.
- `alarm_ack`  in  1  one-cycle clear of `alarm`.
- `pulse_count`  out  8  closed-window count driven to BPM_Monitor; holds between windows.
- `count_valid`  out  1  one-cycle strobe: `pulse_count` updated.
- `window_active`  out  1  a window is being counted.
- `abnormal_streak`  out  4  current consecutive-abnormal count.
- `alarm`  out  1  sticky alarm.

## Operation
- Main FSM, IDLE/RUN:
  - IDLE -> RUN when `enable`=1. Window timer and edge counter clear on entry.
  - RUN -> IDLE when `enable`=0 in any cycle. The open window is discarded: no `count_valid`, `pulse_count` holds, `abnormal_streak` clears, `alarm` holds.
- Edge counting in RUN:
  - Each synchronized rising edge of `pulse_in` increments an 8-bit counter.
  - The counter saturates at 255; it never wraps.
- Window timer counts 0..`WINDOW_CYCLES`-1. In the cycle timer = `WINDOW_CYCLES`-1:
  - `pulse_count` <= sat(counter + edge_this_cycle).
  - Counter <= 0 and timer <= 0; the next window starts immediately with no dead cycles.
  - `count_valid`=1 on the following cycle.
- Eval FSM, runs in parallel with counting: E_IDLE -> E_WAIT on `count_valid` -> E_WAIT for `BPM_LATENCY` cycles -> E_EVAL for 1 cycle -> E_IDLE.
- In E_EVAL, sample `bpm_state_in`:
  - 1: `abnormal_streak` increments, saturating at 15.
  - 0: `abnormal_streak` clears.
  - If the post-update streak >= `ALARM_WINDOWS`, `alarm` <= 1.
- `alarm` clears only on `alarm_ack`. Alarm set and `alarm_ack` in the same cycle: set wins.
- Abort (`enable`=0) during E_WAIT/E_EVAL: the eval FSM returns to E_IDLE with no streak update.

## Timing
- Reset values: `pulse_count`=0, `count_valid`=0, `window_active`=0, `abnormal_streak`=0, `alarm`=0; both FSMs idle.
- `pulse_in` rising -> counted 3 cycles later (2-FF sync plus edge register). Edges arriving within 3 cycles of window end fall into the next window.
- `window_active`=1 the cycle after IDLE->RUN; it drops the cycle after `enable` falls.
- Window end: `count_valid` 1 cycle after the timer terminal cycle. `alarm` rises `BPM_LATENCY`+2 cycles after `count_valid`.
- `WINDOW_CYCLES` > `BPM_LATENCY`+2 is required, so eval always finishes before the next `count_valid`.
- `pulse_count` is stable from `count_valid` until the next `count_valid`.

## Structure
- Shared package (`elderly_pkg`):
  - main and eval state enums.
  - `COUNT_MAX`=8'hFF and `STREAK_MAX`=4'hF.
  - default parameter constants.
- One sub-module, `pulse_edge_sync`: 2-FF synchronizer plus rising-edge detect, same clk and reset; also reusable for other sensor inputs.
- Top level holds the window timer, edge counter, both FSMs and the alarm logic.

## Test plan
Bench parameters: `TICKS_PER_SEC`=10, `WINDOW_SEC`=2 (20-cycle window), `BPM_LATENCY`=1, `ALARM_WINDOWS`=3.
- Reset mid-run with `alarm`=1 -> all outputs 0 the same cycle (asynchronous); no `count_valid` until 21 cycles after `enable` is reasserted.
- `enable`=1, 7 clean pulses inside one window -> single `count_valid` with `pulse_count`=7; second empty window -> `pulse_count`=0.
- Pulse edge detected in the terminal cycle -> counted in the closing window. Pulse arriving 2 cycles before the terminal cycle -> counted in the next window.
- 300 edges in one window (long-window build, `TICKS_PER_SEC`=400) -> `pulse_count`=255, no wrap.
- `bpm_state_in`=1 for 3 windows -> streak 1,2,3 and `alarm`=1 at 3rd E_EVAL. A normal window -> streak 0, `alarm` stays 1. `alarm_ack` -> `alarm`=0. `alarm_ack` coincident with a set -> `alarm` stays 1.
- `enable` dropped at timer=10 -> no `count_valid`, `pulse_count` unchanged, streak cleared, `window_active`=0 next cycle.
